// File: rtl/battleship_pkg.sv
// Shared constants, state encoding and cell-index helper for the battleship
// game stages (placement, firing).
//   GRID_W / GRID_H : grid size in columns / rows
//   CELLS           : number of grid cells, index = y*GRID_W + x
//   state_t         : firing-stage FSM states
//   idx(x,y)        : linear cell index of a coordinate
package battleship_pkg;

    localparam int GRID_W = 6;
    localparam int GRID_H = 6;
    localparam int CELLS  = GRID_W * GRID_H;
    localparam int X_W    = $clog2(GRID_W);
    localparam int Y_W    = $clog2(GRID_H);
    localparam int CELL_W = $clog2(CELLS);

    typedef enum logic [1:0] {
        WAIT_PLACE = 2'd0,
        AIM        = 2'd1,
        RESOLVE    = 2'd2,
        GAME_OVER  = 2'd3
    } state_t;

    function automatic logic [CELL_W-1:0] idx(input logic [X_W-1:0] x,
                                              input logic [Y_W-1:0] y);
        return CELL_W'(y) * CELL_W'(GRID_W) + CELL_W'(x);
    endfunction

endpackage

// File: rtl/battle_fire_controller_if.sv
// Signal bundle of the firing stage.
//   Inputs to the controller : up/down/left/right/fire pulses, both placed fleets,
//                              both placement-complete levels.
//   Outputs of the controller: aim cursor, four shot maps, turn, hit/miss pulses,
//                              game_over, winner_p1.
// Modports: master = the side driving inputs (input stage / bench),
//           slave  = the controller itself.
interface battle_fire_controller_if;
    import battleship_pkg::*;

    logic             up;
    logic             down;
    logic             left;
    logic             right;
    logic             fire;
    logic [CELLS-1:0] placed_ships_p1;
    logic [CELLS-1:0] placed_ships_p2;
    logic             p1_placement_complete;
    logic             p2_placement_complete;

    logic [CELLS-1:0] aim_cursor;
    logic [CELLS-1:0] hits_on_p1;
    logic [CELLS-1:0] misses_on_p1;
    logic [CELLS-1:0] hits_on_p2;
    logic [CELLS-1:0] misses_on_p2;
    logic             turn_is_p1;
    logic             shot_hit;
    logic             shot_miss;
    logic             game_over;
    logic             winner_p1;

    modport master (
        output up, down, left, right, fire,
        output placed_ships_p1, placed_ships_p2,
        output p1_placement_complete, p2_placement_complete,
        input  aim_cursor, hits_on_p1, misses_on_p1, hits_on_p2, misses_on_p2,
        input  turn_is_p1, shot_hit, shot_miss, game_over, winner_p1
    );

    modport slave (
        input  up, down, left, right, fire,
        input  placed_ships_p1, placed_ships_p2,
        input  p1_placement_complete, p2_placement_complete,
        output aim_cursor, hits_on_p1, misses_on_p1, hits_on_p2, misses_on_p2,
        output turn_is_p1, shot_hit, shot_miss, game_over, winner_p1
    );
endinterface

// File: rtl/grid_cursor.sv
// Grid cursor: x/y registers moved by single-cycle pulses, clamped at the grid
// edges (no wrap), with a synchronous clear back to (0,0) and a one-hot decode.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   move_en                 : moves are applied only while high
//   up, down, left, right   : move pulses; opposing pulses cancel on their axis
//   clear                   : return to (0,0); overrides moves
//   x, y                    : registered coordinates
//   one_hot                 : one bit per cell, set at index y*W + x
module grid_cursor #(
    parameter int W = 6,
    parameter int H = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 move_en,
    input  logic                 up,
    input  logic                 down,
    input  logic                 left,
    input  logic                 right,
    input  logic                 clear,
    output logic [$clog2(W)-1:0] x,
    output logic [$clog2(H)-1:0] y,
    output logic [W*H-1:0]       one_hot
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int N  = W * H;
    localparam int NW = $clog2(N);

    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;
    logic [NW-1:0] cell_idx;

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (clear) begin
            x_next = '0;
            y_next = '0;
        end else if (move_en) begin
            if (right && !left && (x_reg < XW'(W - 1)))
                x_next = x_reg + 1'b1;
            else if (left && !right && (x_reg != '0))
                x_next = x_reg - 1'b1;
            // y grows downward: row 0 is the top of the grid
            if (down && !up && (y_reg < YW'(H - 1)))
                y_next = y_reg + 1'b1;
            else if (up && !down && (y_reg != '0))
                y_next = y_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    assign cell_idx = NW'(y_reg) * NW'(W) + NW'(x_reg);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_decode
            assign one_hot[gi] = (cell_idx == NW'(gi));
        end
    endgenerate

    assign x = x_reg;
    assign y = y_reg;
endmodule

// File: rtl/battle_fire_controller.sv
// Firing/turn stage of the battleship game. Waits for both players to finish
// placement, snapshots both fleets, then alternates shots: the player on turn
// moves an aim cursor, fires, the shot is resolved as hit or miss against the
// opponent's fleet, shot maps are updated and the winner is detected.
// Ports:
//   clk, reset : clock, synchronous active-high reset (aborts any game)
//   bus        : battle_fire_controller_if.slave (inputs and outputs listed there)
// Configuration:
//   HIT_AGAIN_EN defined   -> a non-winning hit keeps the turn with the shooter
//   HIT_AGAIN_EN undefined -> turn toggles after every resolved shot
module battle_fire_controller
    import battleship_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    battle_fire_controller_if.slave   bus
);
    state_t state_reg, state_next;

    logic [CELLS-1:0]  fleet_p1_reg, fleet_p2_reg;
    logic [CELLS-1:0]  hits_p1_reg, misses_p1_reg, hits_p2_reg, misses_p2_reg;
    logic              turn_p1_reg, game_over_reg, winner_p1_reg;
    logic [CELL_W-1:0] target_reg;

    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic [CELLS-1:0]  cur_one_hot;
    logic              cursor_clear;

    logic [CELLS-1:0]  opp_fleet, opp_hits, opp_misses, target_bit, new_hits;
    logic              both_placed, target_is_ship, already_shot, shot_valid, win;

    grid_cursor #(.W(GRID_W), .H(GRID_H)) u_cursor (
        .clk     (clk),
        .reset   (reset),
        .move_en (state_reg == AIM),
        .up      (bus.up),
        .down    (bus.down),
        .left    (bus.left),
        .right   (bus.right),
        .clear   (cursor_clear),
        .x       (cur_x),
        .y       (cur_y),
        .one_hot (cur_one_hot)
    );

    // Everything is seen from the shooter's side: "opponent" is the player not on turn.
    always_comb begin
        both_placed    = bus.p1_placement_complete && bus.p2_placement_complete;
        opp_fleet      = turn_p1_reg ? fleet_p2_reg  : fleet_p1_reg;
        opp_hits       = turn_p1_reg ? hits_p2_reg   : hits_p1_reg;
        opp_misses     = turn_p1_reg ? misses_p2_reg : misses_p1_reg;
        // Target for a fire this cycle uses the registered position, so a
        // same-cycle move does not change where the shot lands.
        already_shot   = |((opp_hits | opp_misses) & cur_one_hot);
        shot_valid     = bus.fire && !already_shot;
        target_bit     = CELLS'(1) << target_reg;
        target_is_ship = |(opp_fleet & target_bit);
        new_hits       = opp_hits | (target_is_ship ? target_bit : '0);
        // An empty opponent fleet makes this true on the first resolved shot.
        win            = (new_hits == opp_fleet);
    end

    always_comb begin
        state_next   = state_reg;
        cursor_clear = 1'b0;
        unique case (state_reg)
            WAIT_PLACE: if (both_placed) state_next = AIM;
            AIM:        if (shot_valid)  state_next = RESOLVE;
            RESOLVE: begin
                state_next   = win ? GAME_OVER : AIM;
                cursor_clear = !win;
            end
            GAME_OVER:  state_next = GAME_OVER;
            default:    state_next = WAIT_PLACE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= WAIT_PLACE;
            fleet_p1_reg  <= '0;
            fleet_p2_reg  <= '0;
            hits_p1_reg   <= '0;
            misses_p1_reg <= '0;
            hits_p2_reg   <= '0;
            misses_p2_reg <= '0;
            turn_p1_reg   <= 1'b1;
            game_over_reg <= 1'b0;
            winner_p1_reg <= 1'b0;
            target_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == WAIT_PLACE && both_placed) begin
                fleet_p1_reg <= bus.placed_ships_p1;
                fleet_p2_reg <= bus.placed_ships_p2;
            end
            if (state_reg == AIM && shot_valid)
                target_reg <= idx(cur_x, cur_y);
            if (state_reg == RESOLVE) begin
                if (turn_p1_reg) begin
                    if (target_is_ship) hits_p2_reg   <= hits_p2_reg   | target_bit;
                    else                misses_p2_reg <= misses_p2_reg | target_bit;
                end else begin
                    if (target_is_ship) hits_p1_reg   <= hits_p1_reg   | target_bit;
                    else                misses_p1_reg <= misses_p1_reg | target_bit;
                end
                if (win) begin
                    game_over_reg <= 1'b1;
                    winner_p1_reg <= turn_p1_reg;
                end else begin
`ifdef HIT_AGAIN_EN
                    if (!target_is_ship)
                        turn_p1_reg <= ~turn_p1_reg;
`else
                    turn_p1_reg <= ~turn_p1_reg;
`endif
                end
            end
        end
    end

    assign bus.aim_cursor   = cur_one_hot;
    assign bus.hits_on_p1   = hits_p1_reg;
    assign bus.misses_on_p1 = misses_p1_reg;
    assign bus.hits_on_p2   = hits_p2_reg;
    assign bus.misses_on_p2 = misses_p2_reg;
    assign bus.turn_is_p1   = turn_p1_reg;
    assign bus.shot_hit     = (state_reg == RESOLVE) && target_is_ship;
    assign bus.shot_miss    = (state_reg == RESOLVE) && !target_is_ship;
    assign bus.game_over    = game_over_reg;
    assign bus.winner_p1    = winner_p1_reg;
endmodule

// File: tb/tb_battle_fire_controller.sv
// Directed testbench for battle_fire_controller. Inputs change 1 time unit after
// a rising edge and outputs are checked at the same point, i.e. they show the
// state produced by the preceding edge.
module tb_battle_fire_controller;
    import battleship_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    battle_fire_controller_if bus();

    battle_fire_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Apply one cycle of move/fire pulses, then drop them after the edge.
    task automatic cyc(input logic u, input logic d, input logic l, input logic r, input logic f);
        bus.up = u; bus.down = d; bus.left = l; bus.right = r; bus.fire = f;
        @(posedge clk);
        #1;
        bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0; bus.fire = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic start_game(input logic [CELLS-1:0] f1, input logic [CELLS-1:0] f2);
        reset = 1'b1;
        bus.p1_placement_complete = 1'b0;
        bus.p2_placement_complete = 1'b0;
        idle();
        reset = 1'b0;
        bus.placed_ships_p1 = f1;
        bus.placed_ships_p2 = f2;
        bus.p1_placement_complete = 1'b1;
        bus.p2_placement_complete = 1'b1;
        idle();
    endtask

    localparam logic [CELLS-1:0] C0  = 36'h1;
    localparam logic [CELLS-1:0] C1  = 36'h2;
    localparam logic [CELLS-1:0] C5  = 36'h20;
    localparam logic [CELLS-1:0] C7  = 36'h80;
    localparam logic [CELLS-1:0] C35 = 36'h8_0000_0000;

    initial begin
        reset = 1'b1;
        bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0; bus.fire = 0;
        bus.placed_ships_p1 = '0;
        bus.placed_ships_p2 = '0;
        bus.p1_placement_complete = 0;
        bus.p2_placement_complete = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        check("rst_aim", bus.aim_cursor, C0);
        check("rst_maps", bus.hits_on_p1 | bus.misses_on_p1 | bus.hits_on_p2 | bus.misses_on_p2, 0);
        check("rst_turn", bus.turn_is_p1, 1);
        check("rst_pulses", {bus.shot_hit, bus.shot_miss}, 0);
        check("rst_over", {bus.game_over, bus.winner_p1}, 0);

        // Game A: P1 fleet cell 0, P2 fleet cell 7; cursor clamping, then winning hit
        start_game(C0, C7);
        // Fleet inputs changing after the start must be ignored.
        bus.placed_ships_p2 = '1;
        check("a_aim0", bus.aim_cursor, C0);
        check("a_turn", bus.turn_is_p1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        check("a_aim_x5", bus.aim_cursor, C5);
        cyc(0, 0, 0, 1, 0);
        check("a_clamp_r", bus.aim_cursor, C5);
        cyc(1, 0, 0, 0, 0);
        check("a_clamp_up", bus.aim_cursor, C5);
        cyc(0, 0, 1, 1, 0);
        check("a_cancel", bus.aim_cursor, C5);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("a_aim7", bus.aim_cursor, C7);
        cyc(0, 0, 0, 0, 1);
        check("a_hit_pulse", {bus.shot_hit, bus.shot_miss}, 2'b10);
        idle();
        check("a_hit_pulse_end", {bus.shot_hit, bus.shot_miss}, 0);
        check("a_hits_p2", bus.hits_on_p2, C7);
        check("a_over", {bus.game_over, bus.winner_p1}, 2'b11);
        cyc(0, 0, 0, 1, 1);
        check("a_frozen_aim", bus.aim_cursor, C7);
        check("a_frozen_pulse", {bus.shot_hit, bus.shot_miss}, 0);
        check("a_frozen_over", bus.game_over, 1);

        // Game B: P1 fleet cell 0, P2 fleet cells 7 and 35; misses, repeated shot, hit
        bus.placed_ships_p1 = '0;
        start_game(C0, C7 | C35);
        cyc(0, 0, 0, 0, 1);
        check("b_miss_pulse", {bus.shot_hit, bus.shot_miss}, 2'b01);
        idle();
        check("b_miss_map", bus.misses_on_p2, C0);
        check("b_turn_p2", bus.turn_is_p1, 0);
        check("b_aim_back", bus.aim_cursor, C0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        check("b_p2_miss_pulse", {bus.shot_hit, bus.shot_miss}, 2'b01);
        idle();
        check("b_p2_miss_map", bus.misses_on_p1, C1);
        check("b_turn_p1", bus.turn_is_p1, 1);
        cyc(0, 0, 0, 0, 1);
        check("b_repeat_pulse", {bus.shot_hit, bus.shot_miss}, 0);
        idle();
        check("b_repeat_turn", bus.turn_is_p1, 1);
        check("b_repeat_map", bus.misses_on_p2, C0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        check("b_hit_pulse", {bus.shot_hit, bus.shot_miss}, 2'b10);
        idle();
        check("b_hit_map", bus.hits_on_p2, C7);
        check("b_not_over", bus.game_over, 0);
        check("b_aim_reset", bus.aim_cursor, C0);
`ifdef HIT_AGAIN_EN
        check("b_turn_kept", bus.turn_is_p1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0);
        check("b_aim35", bus.aim_cursor, C35);
        cyc(0, 0, 0, 0, 1);
        idle();
        check("b_final_hits", bus.hits_on_p2, C7 | C35);
        check("b_win_p1", {bus.game_over, bus.winner_p1}, 2'b11);
`else
        check("b_turn_toggled", bus.turn_is_p1, 0);
        cyc(0, 0, 0, 0, 1);
        check("b_p2_hit_pulse", {bus.shot_hit, bus.shot_miss}, 2'b10);
        idle();
        check("b_hits_p1", bus.hits_on_p1, C0);
        check("b_win_p2", {bus.game_over, bus.winner_p1}, 2'b10);
`endif

        // Game C: reset while in RESOLVE, then nothing starts with only one flag
        start_game(C0, C7);
        cyc(0, 0, 0, 1, 1);
        check("c_resolve", bus.shot_miss, 1);
        reset = 1'b1;
        bus.p1_placement_complete = 1'b1;
        bus.p2_placement_complete = 1'b0;
        idle();
        reset = 1'b0;
        check("c_rst_maps", bus.hits_on_p1 | bus.misses_on_p1 | bus.hits_on_p2 | bus.misses_on_p2, 0);
        check("c_rst_aim", bus.aim_cursor, C0);
        check("c_rst_turn", {bus.turn_is_p1, bus.shot_hit, bus.shot_miss}, 3'b100);
        cyc(0, 0, 0, 1, 1);
        check("c_wait_pulse", {bus.shot_hit, bus.shot_miss}, 0);
        idle();
        check("c_wait_aim", bus.aim_cursor, C0);
        check("c_wait_map", bus.misses_on_p2, 0);

        // Game D: empty P2 fleet, first valid shot wins for P1
        start_game(C0, '0);
        cyc(0, 0, 0, 0, 1);
        check("d_miss_pulse", {bus.shot_hit, bus.shot_miss}, 2'b01);
        idle();
        check("d_miss_map", bus.misses_on_p2, C0);
        check("d_win", {bus.game_over, bus.winner_p1}, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
